// File: rtl/cskip_a16.sv
// 16-bit unsigned carry-skip adder: four 4-bit ripple blocks, each with a group-propagate bypass mux.
// Latency: one cycle; S/cout register x + y on every rising clk edge.
// Backpressure: none; accepts one addition per cycle with no handshake or enable.
module cskip_a16 (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] x,
    input  logic [15:0] y,
    output logic [15:0] S,
    output logic        cout
);

    logic [15:0] p;
    logic [15:0] g;
    logic [15:0] sum_c;
    logic [4:0]  blk_c;  // blk_c[k] is the carry into block k; blk_c[4] is the final carry
    logic [3:0]  blk_p;  // group propagate per block, selects the bypass path

    // Bitwise propagate/generate terms feeding every block.
    always_comb begin
        p = x ^ y;
        g = x & y;
    end

    // Ripple inside each block, then a skip mux chooses between the ripple carry-out
    // and the block's own carry-in when every bit of the block propagates.
    always_comb begin
        logic rc;
        rc       = 1'b0;
        sum_c    = '0;
        blk_c    = '0;
        blk_p    = '0;
        blk_c[0] = 1'b0;
        for (int k = 0; k < 4; k++) begin
            rc = blk_c[k];
            for (int i = 0; i < 4; i++) begin
                sum_c[4*k+i] = p[4*k+i] ^ rc;
                rc           = g[4*k+i] | (p[4*k+i] & rc);
            end
            blk_p[k]   = &p[4*k +: 4];
            blk_c[k+1] = blk_p[k] ? blk_c[k] : rc;
        end
    end

    // Output registers; reset clears them immediately, independent of the clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            S    <= 16'h0000;
            cout <= 1'b0;
        end else begin
            S    <= sum_c;
            cout <= blk_c[4];
        end
    end

endmodule

// File: tb/tb_cskip_a16.sv
module tb_cskip_a16;

    logic        clk;
    logic        rst;
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] S;
    logic        cout;

    int checks;
    int errors;

    typedef struct {
        string       name;
        logic [15:0] vx;
        logic [15:0] vy;
        logic [15:0] es;
        logic        ec;
    } vec_t;

    vec_t vecs[8];

    cskip_a16 dut (
        .clk  (clk),
        .rst  (rst),
        .x    (x),
        .y    (y),
        .S    (S),
        .cout (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [16:0] act, input logic [16:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    // Watchdog so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog expired got timeout expected finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "timeout");
    end

    initial begin
        logic [16:0] prev;
        checks = 0;
        errors = 0;

        vecs[0] = '{"add_a0a0",  16'hA0A0, 16'hA0A0, 16'h4140, 1'b1};
        vecs[1] = '{"add_58f4",  16'h58F4, 16'hF4F4, 16'h4DE8, 1'b1};
        vecs[2] = '{"add_0f3d",  16'h0F3D, 16'h0F0F, 16'h1E4C, 1'b0};
        vecs[3] = '{"add_c8ca",  16'hC8CA, 16'hC8CA, 16'h9194, 1'b1};
        vecs[4] = '{"skip_gen0", 16'hFFFF, 16'h0001, 16'h0000, 1'b1};
        vecs[5] = '{"skip_all",  16'hFFFF, 16'h0000, 16'hFFFF, 1'b0};
        vecs[6] = '{"skip_all2", 16'h5555, 16'hAAAA, 16'hFFFF, 1'b0};
        vecs[7] = '{"blk1_gen",  16'h00F0, 16'h0010, 16'h0100, 1'b0};

        // Reset without any clock edge.
        rst = 1'b0;
        x   = 16'hFFFF;
        y   = 16'hFFFF;
        #2;
        rst = 1'b1;
        #1;
        check("reset_async", {cout, S}, 17'h00000);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset_hold", {cout, S}, 17'h00000);
        @(posedge clk);
        #1;
        check("reset_first", {cout, S}, {1'b1, 16'hFFFE});

        // Directed table, back-to-back: each result appears one edge later,
        // and new inputs must not disturb outputs before that edge.
        prev = {1'b1, 16'hFFFE};
        for (int i = 0; i < 8; i++) begin
            x = vecs[i].vx;
            y = vecs[i].vy;
            #2;
            check({vecs[i].name, "_hold"}, {cout, S}, prev);
            @(posedge clk);
            #1;
            check(vecs[i].name, {cout, S}, {vecs[i].ec, vecs[i].es});
            prev = {vecs[i].ec, vecs[i].es};
        end

        // Mid-stream reset pulse between edges, then first edge captures current inputs.
        x = 16'h1234;
        y = 16'h4321;
        #2;
        rst = 1'b1;
        #1;
        check("reset_mid", {cout, S}, 17'h00000);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("reset_mid_first", {cout, S}, {1'b0, 16'h5555});

        // Random sweep with periodic asynchronous reset pulses.
        for (int i = 0; i < 10000; i++) begin
            logic [16:0] ref_sum;
            x = 16'($urandom);
            y = 16'($urandom);
            ref_sum = {1'b0, x} + {1'b0, y};
            @(posedge clk);
            #1;
            check("random", {cout, S}, ref_sum);
            if (i % 1000 == 500) begin
                #1;
                rst = 1'b1;
                #1;
                check("random_reset", {cout, S}, 17'h00000);
                #1;
                rst = 1'b0;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
